// File: rtl/rst_timebase_gen_pkg.sv
// Shared state encodings and default timing constants for the reset/timebase generator.
package rst_timebase_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int DEF_STABLE_CYCLES = 1000;
  localparam int DEF_DIV_US        = 20;
  localparam int DEF_DIV_MS        = 1000;

  localparam logic [7:0] LOSS_MAX  = 8'd255;

endpackage

// File: rtl/rst_timebase_gen_tick_divider.sv
// Enable-driven modulo-DIV counter; tick is high on the enabled cycle that completes a period.
module tick_divider #(
  parameter int DIV = 20
) (
  input  logic CLK_20MHZ,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            W    = $clog2(DIV);
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK_20MHZ) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  // Combinational so a cascaded stage can fire in the same cycle as its enable.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/rst_timebase_gen.sv
// Lock-qualified system reset plus 1 us / 1 ms strobes for the 20 MHz domain.
// Optional lock-loss event counter built only when RST_TIMEBASE_LOSS_CNT_EN is defined.
module rst_timebase_gen
  import rst_timebase_gen_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int DIV_US        = DEF_DIV_US,
  parameter int DIV_MS        = DEF_DIV_MS
) (
  input  logic       CLK_20MHZ,
  input  logic       RST,
  input  logic       LOCKED,
  input  logic       CLR_LOST,
  output logic       SYS_RST,
  output logic       READY,
  output logic       TICK_1US,
  output logic       TICK_1MS,
  output logic       LOCK_LOST,
  output logic [7:0] LOSS_COUNT
);

  localparam int               SW        = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);

  logic          lock_meta;
  logic          lock_s;
  state_e        state;
  state_e        next_state;
  logic [SW-1:0] cnt;
  logic [SW-1:0] cnt_next;
  logic          loss;
  logic          run_q;
  logic          tb_clr;
  logic          us_en;

  // NOTE: non-blocking assignments in clocked blocks so both flops sample pre-edge values.
  always_ff @(posedge CLK_20MHZ) begin
    if (RST) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= LOCKED;
      lock_s    <= lock_meta;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    loss       = 1'b0;
    case (state)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (lock_s) next_state = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STAB_LAST) begin
          next_state = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + SW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
          loss       = 1'b1;
        end
      end
      default: begin
        next_state = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_20MHZ) begin
    if (RST) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      SYS_RST   <= 1'b1;
      READY     <= 1'b0;
      LOCK_LOST <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      SYS_RST <= (next_state != RUN);
      READY   <= (next_state == RUN);
      run_q   <= (state == RUN);
      // A loss in the same cycle as a clear request keeps the flag set.
      if (loss) begin
        LOCK_LOST <= 1'b1;
      end else if (CLR_LOST) begin
        LOCK_LOST <= 1'b0;
      end
    end
  end

  // run_q delays the us stage by one cycle so the first strobe lands DIV_US cycles after READY.
  assign tb_clr = RST || (next_state != RUN);
  assign us_en  = run_q && (state == RUN);

  tick_divider #(.DIV(DIV_US)) u_us_div (
    .CLK_20MHZ (CLK_20MHZ),
    .clr       (tb_clr),
    .en        (us_en),
    .tick      (TICK_1US)
  );

  tick_divider #(.DIV(DIV_MS)) u_ms_div (
    .CLK_20MHZ (CLK_20MHZ),
    .clr       (tb_clr),
    .en        (TICK_1US),
    .tick      (TICK_1MS)
  );

`ifdef RST_TIMEBASE_LOSS_CNT_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge CLK_20MHZ) begin
    if (RST) begin
      loss_cnt <= 8'd0;
    end else if (loss && (loss_cnt != LOSS_MAX)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign LOSS_COUNT = loss_cnt;
`else
  assign LOSS_COUNT = 8'd0;
`endif

endmodule

// File: tb/tb_rst_timebase_gen.sv
// Directed bench for rst_timebase_gen with STABLE_CYCLES=16, DIV_US=20, DIV_MS=4.
module tb_rst_timebase_gen;

  localparam int SC = 16;
  localparam int DU = 20;
  localparam int DM = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       clr_lost;
  logic       sys_rst;
  logic       ready;
  logic       tick_1us;
  logic       tick_1ms;
  logic       lock_lost;
  logic [7:0] loss_count;

  int checks   = 0;
  int errors   = 0;
  int exp_loss = 0;

  always #5 clk = ~clk;

  rst_timebase_gen #(
    .STABLE_CYCLES (SC),
    .DIV_US        (DU),
    .DIV_MS        (DM)
  ) dut (
    .CLK_20MHZ  (clk),
    .RST        (rst),
    .LOCKED     (locked),
    .CLR_LOST   (clr_lost),
    .SYS_RST    (sys_rst),
    .READY      (ready),
    .TICK_1US   (tick_1us),
    .TICK_1MS   (tick_1ms),
    .LOCK_LOST  (lock_lost),
    .LOSS_COUNT (loss_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_lc(input int n);
`ifdef RST_TIMEBASE_LOSS_CNT_EN
    return (n > 255) ? 32'd255 : 32'(n);
`else
    return (n >= 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  initial begin
    int us_n, ms_n, us_bad, ms_bad, idle_ticks;

    // Power-up: reset held 3 edges with lock already present.
    rst      = 1'b1;
    locked   = 1'b1;
    clr_lost = 1'b0;
    step(3);
    check("rst_sys_rst",   sys_rst,    1);
    check("rst_ready",     ready,      0);
    check("rst_tick_us",   tick_1us,   0);
    check("rst_tick_ms",   tick_1ms,   0);
    check("rst_lock_lost", lock_lost,  0);
    check("rst_loss_cnt",  loss_count, 0);

    rst = 1'b0;
    step(SC + 2);
    check("pwr_sys_rst_e18", sys_rst, 1);
    check("pwr_ready_e18",   ready,   0);
    step(1);
    check("pwr_sys_rst_e19", sys_rst,   0);
    check("pwr_ready_e19",   ready,     1);
    check("pwr_lock_lost",   lock_lost, 0);

    // Timebase: 400 cycles counted from the edge READY rose.
    us_n = 0; ms_n = 0; us_bad = 0; ms_bad = 0;
    for (int k = 1; k <= 400; k++) begin
      step(1);
      if (tick_1us) us_n++;
      if (tick_1ms) ms_n++;
      if (tick_1us !== ((k % DU) == 0)) us_bad++;
      if (tick_1ms !== ((k % (DU * DM)) == 0)) ms_bad++;
    end
    check("tb_us_count",     us_n,   20);
    check("tb_ms_count",     ms_n,   5);
    check("tb_us_placement", us_bad, 0);
    check("tb_ms_placement", ms_bad, 0);

    // Lock loss while running.
    locked = 1'b0;
    step(2);
    check("loss_sys_rst_e2", sys_rst, 0);
    step(1);
    exp_loss++;
    check("loss_sys_rst_e3", sys_rst,    1);
    check("loss_ready_e3",   ready,      0);
    check("loss_lock_lost",  lock_lost,  1);
    check("loss_tick_us",    tick_1us,   0);
    check("loss_count_1",    loss_count, exp_lc(exp_loss));
    idle_ticks = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (tick_1us || tick_1ms) idle_ticks++;
    end
    check("loss_ticks_stopped", idle_ticks, 0);

    locked = 1'b1;
    step(SC + 2);
    check("relock_sys_rst_e18", sys_rst, 1);
    step(1);
    check("relock_sys_rst_e19", sys_rst,   0);
    check("relock_lock_lost",   lock_lost, 1);

    // Reset mid-operation clears everything including the sticky flag.
    step(5);
    rst = 1'b1;
    step(1);
    exp_loss = 0;
    check("midrst_sys_rst",   sys_rst,    1);
    check("midrst_ready",     ready,      0);
    check("midrst_lock_lost", lock_lost,  0);
    check("midrst_loss_cnt",  loss_count, 0);
    check("midrst_tick_us",   tick_1us,   0);

    // One-cycle glitch while the stable count sits at 10.
    rst = 1'b0;
    step(13);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(5);
    check("glitch_sys_rst_e19", sys_rst, 1);
    step(13);
    check("glitch_sys_rst_e32", sys_rst, 1);
    step(1);
    check("glitch_sys_rst_e33", sys_rst, 0);
    check("glitch_ready_e33",   ready,   1);

    // Clear request coinciding with a new loss.
    step(10);
    locked = 1'b0;
    step(2);
    clr_lost = 1'b1;
    step(1);
    clr_lost = 1'b0;
    exp_loss++;
    check("clr_vs_loss_sys_rst", sys_rst,    1);
    check("clr_vs_loss_flag",    lock_lost,  1);
    check("clr_vs_loss_count",   loss_count, exp_lc(exp_loss));
    step(3);
    check("lost_sticky", lock_lost, 1);
    clr_lost = 1'b1;
    step(1);
    clr_lost = 1'b0;
    check("clr_alone", lock_lost, 0);

    // Repeated loss events to exercise the saturating counter.
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      step(SC + 3);
      if (i == 0 || i == 299) check("sat_reached_run", ready, 1);
      locked = 1'b0;
      step(3);
      exp_loss++;
      if (i == 99) check("sat_count_mid", loss_count, exp_lc(exp_loss));
    end
    check("sat_count_final", loss_count, exp_lc(exp_loss));
    check("sat_lock_lost",   lock_lost,  1);
    check("sat_sys_rst",     sys_rst,    1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
